// File: rtl/edge_bbox_tracker.sv
// Per-frame bounding box and edge-pixel count over a raster-order thresholded edge stream.
// One registered result is published per completed frame, with a single-cycle box_valid_o pulse.
module edge_bbox_tracker #(
    parameter int LINE_WIDTH     = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int PIXEL_DEPTH    = 8,
    parameter int MIN_EDGE_COUNT = 16,
    parameter int COUNT_WIDTH    = 20,
    localparam int XW = $clog2(LINE_WIDTH),
    localparam int YW = $clog2(FRAME_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [PIXEL_DEPTH-1:0] inputEdge,
    input  logic                   frame_start_i,
    output logic                   box_valid_o,
    output logic                   found_o,
    output logic [XW-1:0]          x_min_o,
    output logic [XW-1:0]          x_max_o,
    output logic [YW-1:0]          y_min_o,
    output logic [YW-1:0]          y_max_o,
    output logic [XW-1:0]          x_center_o,
    output logic [COUNT_WIDTH-1:0] edge_count_o
);

    localparam logic [XW-1:0]          X_LAST    = XW'(LINE_WIDTH - 1);
    localparam logic [YW-1:0]          Y_LAST    = YW'(FRAME_HEIGHT - 1);
    localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = COUNT_WIDTH'(MIN_EDGE_COUNT);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        SCAN     = 1'b1
    } state_t;

    state_t state, state_next;

    logic [XW-1:0]          x_q, px, nx;
    logic [YW-1:0]          y_q, py, ny;
    logic [COUNT_WIDTH-1:0] count_q, base_count, new_count;
    logic [XW-1:0]          xmin_q, xmax_q, base_xmin, base_xmax, new_xmin, new_xmax;
    logic [YW-1:0]          ymin_q, ymax_q, base_ymin, base_ymax, new_ymin, new_ymax;
    logic [XW:0]            x_sum;
    logic                   accept, is_edge, first_edge, frame_end, new_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (frame_start_i) begin
            state_next = SCAN;
        end
    end

    // A SOF pixel sits at (0,0) and starts from empty accumulators, whatever came before it.
    always_comb begin
        accept     = valid_i && ((state == SCAN) || frame_start_i);
        is_edge    = accept && inputEdge[PIXEL_DEPTH-1];
        px         = frame_start_i ? '0 : x_q;
        py         = frame_start_i ? '0 : y_q;
        base_count = frame_start_i ? '0 : count_q;
        base_xmin  = frame_start_i ? '0 : xmin_q;
        base_xmax  = frame_start_i ? '0 : xmax_q;
        base_ymin  = frame_start_i ? '0 : ymin_q;
        base_ymax  = frame_start_i ? '0 : ymax_q;
        first_edge = (base_count == '0);
        frame_end  = accept && !frame_start_i && (x_q == X_LAST) && (y_q == Y_LAST);

        nx = (px == X_LAST) ? '0 : px + XW'(1);
        ny = (px == X_LAST) ? py + YW'(1) : py;

        new_count = base_count;
        new_xmin  = base_xmin;
        new_xmax  = base_xmax;
        new_ymin  = base_ymin;
        new_ymax  = base_ymax;
        if (is_edge) begin
            new_count = (&base_count) ? base_count : base_count + COUNT_WIDTH'(1);
            new_xmin  = (first_edge || px < base_xmin) ? px : base_xmin;
            new_xmax  = (first_edge || px > base_xmax) ? px : base_xmax;
            new_ymin  = (first_edge || py < base_ymin) ? py : base_ymin;
            new_ymax  = (first_edge || py > base_ymax) ? py : base_ymax;
        end

        new_found = (new_count >= MIN_COUNT);
        x_sum     = {1'b0, new_xmin} + {1'b0, new_xmax};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            count_q      <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymin_q       <= '0;
            ymax_q       <= '0;
            box_valid_o  <= 1'b0;
            found_o      <= 1'b0;
            x_min_o      <= '0;
            x_max_o      <= '0;
            y_min_o      <= '0;
            y_max_o      <= '0;
            x_center_o   <= '0;
            edge_count_o <= '0;
        end else begin
            box_valid_o <= 1'b0;
            if (frame_end) begin
                box_valid_o  <= 1'b1;
                found_o      <= new_found;
                x_min_o      <= new_found ? new_xmin : '0;
                x_max_o      <= new_found ? new_xmax : '0;
                y_min_o      <= new_found ? new_ymin : '0;
                y_max_o      <= new_found ? new_ymax : '0;
                x_center_o   <= new_found ? x_sum[XW:1] : '0;
                edge_count_o <= new_count;
                x_q          <= '0;
                y_q          <= '0;
                count_q      <= '0;
                xmin_q       <= '0;
                xmax_q       <= '0;
                ymin_q       <= '0;
                ymax_q       <= '0;
            end else if (accept) begin
                x_q     <= nx;
                y_q     <= ny;
                count_q <= new_count;
                xmin_q  <= new_xmin;
                xmax_q  <= new_xmax;
                ymin_q  <= new_ymin;
                ymax_q  <= new_ymax;
            end else if (frame_start_i) begin
                x_q     <= '0;
                y_q     <= '0;
                count_q <= '0;
                xmin_q  <= '0;
                xmax_q  <= '0;
                ymin_q  <= '0;
                ymax_q  <= '0;
            end
        end
    end

endmodule
